// File: rtl/sdtimer_pkg.sv
// Shared definitions for the sdtimer down-counter: FSM state encoding,
// default and legal counter widths.
package sdtimer_pkg;

    localparam int DEFAULT_N = 8;
    localparam int N_MIN     = 2;
    localparam int N_MAX     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    function automatic logic width_ok(input int n);
        return (n >= N_MIN) && (n <= N_MAX);
    endfunction

endpackage

// File: rtl/sdtimer_if.sv
// Load/control and status bundle of the sdtimer. The master drives the
// load value and strobes; the slave (the timer) returns count and status.
interface sdtimer_if
    import sdtimer_pkg::*;
#(
    parameter int N = DEFAULT_N
) ();

    logic [N-1:0] D;
    logic         EN;
    logic         PL;
    logic         AR;
    logic [N-1:0] Q;
    logic         BOUT;
    logic         BUSY;
    logic         DONE;

    modport master (
        output D, EN, PL, AR,
        input  Q, BOUT, BUSY, DONE
    );

    modport slave (
        input  D, EN, PL, AR,
        output Q, BOUT, BUSY, DONE
    );

endinterface

// File: rtl/sdtimer_sdec.sv
// N-bit unsigned decrementer with a "value is one" detect; the timer's
// terminal cycle is keyed off the count reaching one, not zero.
module sdec_generic #(
    parameter int N = 8
) (
    input  logic [N-1:0] value,
    output logic [N-1:0] dec,
    output logic         is_one
);

    localparam logic [N-1:0] ONE = N'(1);

    assign dec    = value - ONE;
    assign is_one = (value == ONE);

endmodule

// File: rtl/sdtimer.sv
// Loadable down-counter with optional auto-reload, a one-cycle borrow
// pulse on each terminal event, and IDLE/RUN/DONE status.
module sdtimer
    import sdtimer_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic      CLK,
    input  logic      RST,
    sdtimer_if.slave  bus
);

    generate
        if (!width_ok(N)) begin : g_bad_width
            $error("sdtimer: N must lie in 2..32");
        end
    endgenerate

    state_e       state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] rld_q, rld_d;
    logic         bout_q, bout_d;

    logic [N-1:0] dec_val;
    logic         is_one;
    logic         tick;
    logic         terminal;

    sdec_generic #(.N(N)) u_sdec (
        .value  (q_q),
        .dec    (dec_val),
        .is_one (is_one)
    );

    // A count step only happens in RUN without a load; the load strobe always wins.
    assign tick     = !bus.PL && bus.EN && (state_q == ST_RUN);
    assign terminal = tick && is_one;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.PL) begin
            state_d = (bus.D != '0) ? ST_RUN : ST_IDLE;
        end else if (terminal && !bus.AR) begin
            state_d = ST_DONE;
        end
    end

    // A zero load value lands as zero in both registers, so loads need no special case here.
    always_comb begin
        q_d    = q_q;
        rld_d  = rld_q;
        bout_d = terminal;
        if (bus.PL) begin
            q_d   = bus.D;
            rld_d = bus.D;
        end else if (terminal) begin
            q_d = bus.AR ? rld_q : '0;
        end else if (tick) begin
            q_d = dec_val;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_q    <= '0;
            rld_q  <= '0;
            bout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            rld_q  <= rld_d;
            bout_q <= bout_d;
        end
    end

    always_comb begin
        bus.Q    = q_q;
        bus.BOUT = bout_q;
        bus.BUSY = (state_q == ST_RUN);
        bus.DONE = (state_q == ST_DONE);
    end

    // Inputs must be stable, known values when the clock samples them.
    a_inputs_known : assert property (@(posedge CLK) disable iff (RST)
        !$isunknown({bus.D, bus.EN, bus.PL, bus.AR}));

    a_run_nonzero : assert property (@(posedge CLK) disable iff (RST)
        (state_q == ST_RUN) |-> (q_q != '0));

    a_state_legal : assert property (@(posedge CLK) disable iff (RST)
        state_q inside {ST_IDLE, ST_RUN, ST_DONE});

endmodule
